lsu_mem_port: RTL

//  Load/store unit between the EX/MEM pipeline stage and the data memory (synchronous read, byte-masked write).

---
 rtl/lsu_pkg.sv | 47 ++++
 rtl/lsu_mem_port_load_align.sv | 46 ++++
 rtl/lsu_mem_port.sv | 136 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : lsu_pkg                                                        |
// | Purpose   : Shared types, width codes and store formatting for the LSU.    |
// | Contents  : RV32I funct3 width codes, FSM state type, fault code type,     |
// |             store_format() -> {lane-replicated data, byte mask}.           |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package lsu_pkg;

   localparam logic [2:0] c_f3_b  = 3'b000;
   localparam logic [2:0] c_f3_h  = 3'b001;
   localparam logic [2:0] c_f3_w  = 3'b010;
   localparam logic [2:0] c_f3_bu = 3'b100;
   localparam logic [2:0] c_f3_hu = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } lsu_state_t;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'b00,
      FAULT_MISALIGN = 2'b01,
      FAULT_RANGE    = 2'b10,
      FAULT_ILLEGAL  = 2'b11
   } fault_t;

   // Returns {data[31:0], mask[3:0]}. Data is replicated into every lane so
   // the memory only needs the mask to pick the right bytes.
   function automatic logic [35:0] store_format(input logic [2:0]  funct3,
                                                input logic [1:0]  off,
                                                input logic [31:0] data);
      logic [35:0] r;
      r = '0;
      case (funct3)
         c_f3_b:  r = {{4{data[7:0]}}, 4'b0001 << off};
         c_f3_h:  r = {{2{data[15:0]}}, (off[1] ? 4'b1100 : 4'b0011)};
         c_f3_w:  r = {data, 4'b1111};
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_mem_port_load_align.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : lsu_mem_port_load_align                                        |
// | Purpose   : Combinational load-data extraction and sign/zero extension.    |
// | Ports     : rdata     in  32  raw memory word                              |
// |             funct3    in   3  load width code                              |
// |             off       in   2  byte offset addr[1:0]                        |
// |             load_data out 32  formatted result                             |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module lsu_mem_port_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   output logic [31:0] load_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte = rdata[7:0];
      case (off)
         2'd0:    w_byte = rdata[7:0];
         2'd1:    w_byte = rdata[15:8];
         2'd2:    w_byte = rdata[23:16];
         default: w_byte = rdata[31:24];
      endcase
      w_half = off[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      load_data = rdata;
      case (funct3)
         c_f3_b:  load_data = {{24{w_byte[7]}}, w_byte};
         c_f3_bu: load_data = {24'd0, w_byte};
         c_f3_h:  load_data = {{16{w_half[15]}}, w_half};
         c_f3_hu: load_data = {16'd0, w_half};
         default: load_data = rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : lsu_mem_port                                                   |
// | Purpose   : Load/store unit between EX/MEM and a synchronous data memory.  |
// |             One transaction at a time: IDLE -> ACCESS -> RESP, or          |
// |             IDLE -> RESP directly for faulting requests.                   |
// | Ports     : clk, rst_n (sync, active low)                                  |
// |             req_*        request handshake, is_load/is_store/funct3/addr   |
// |             resp_*       response handshake, load_data_o, fault_o          |
// |             mem_*        address, strobes, write data/mask, read data      |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int MSIZE = 255
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        is_load_i,
   input  logic        is_store_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] store_data_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] load_data_o,
   output logic [1:0]  fault_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic        mem_re_o,
   output logic [31:0] mem_W_data_o,
   output logic [3:0]  mem_W_mask_o,
   input  logic [31:0] mem_R_data_i
);

   localparam logic [29:0] c_msize = 30'(MSIZE);

   lsu_state_t  r_state;
   lsu_state_t  w_next;
   logic        r_is_load;
   logic        r_is_store;
   logic [2:0]  r_funct3;
   logic [31:0] r_addr;
   logic [31:0] r_store_data;
   fault_t      r_fault;

   fault_t      w_req_fault;
   logic        w_illegal;
   logic        w_misalign;
   logic        w_range;
   logic [35:0] w_fmt;
   logic [31:0] w_load_aligned;

   // Classification works on the live request inputs so the fault can be
   // latched together with the request on the accepting edge.
   always_comb begin
      w_illegal  = (is_load_i == is_store_i)
                 || (is_load_i  && ((funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11)))
                 || (is_store_i && (funct3_i > 3'b010));
      w_misalign = ((funct3_i[1:0] == 2'b01) && addr_i[0])
                 || ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
      w_range    = (addr_i[31:2] > c_msize);
      w_req_fault = FAULT_NONE;
      if (w_illegal)
         w_req_fault = FAULT_ILLEGAL;
      else if (w_misalign)
         w_req_fault = FAULT_MISALIGN;
      else if (w_range)
         w_req_fault = FAULT_RANGE;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (req_valid_i)
               w_next = (w_req_fault != FAULT_NONE) ? S_RESP : S_ACCESS;
         end
         S_ACCESS: w_next = S_RESP;
         S_RESP: begin
            if (resp_ready_i)
               w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_is_load    <= 1'b0;
         r_is_store   <= 1'b0;
         r_funct3     <= 3'b000;
         r_addr       <= 32'd0;
         r_store_data <= 32'd0;
         r_fault      <= FAULT_NONE;
      end else begin
         r_state <= w_next;
         if ((r_state == S_IDLE) && req_valid_i) begin
            r_is_load    <= is_load_i;
            r_is_store   <= is_store_i;
            r_funct3     <= funct3_i;
            r_addr       <= addr_i;
            r_store_data <= store_data_i;
            r_fault      <= w_req_fault;
         end
      end
   end

   assign w_fmt = store_format(r_funct3, r_addr[1:0], r_store_data);

   lsu_mem_port_load_align u_load_align (
      .rdata     (mem_R_data_i),
      .funct3    (r_funct3),
      .off       (r_addr[1:0]),
      .load_data (w_load_aligned)
   );

   // Strobes are qualified by rst_n so a reset landing on the ACCESS edge
   // cannot commit a store or disturb the memory read register.
   assign req_ready_o  = (r_state == S_IDLE);
   assign mem_addr_o   = r_addr;
   assign mem_re_o     = (r_state == S_ACCESS) && r_is_load  && rst_n;
   assign mem_we_o     = (r_state == S_ACCESS) && r_is_store && rst_n;
   assign mem_W_data_o = (r_state != S_IDLE) ? w_fmt[35:4] : 32'd0;
   assign mem_W_mask_o = ((r_state == S_ACCESS) && r_is_store) ? w_fmt[3:0] : 4'b0000;
   assign resp_valid_o = (r_state == S_RESP);
   assign fault_o      = (r_state == S_RESP) ? r_fault : FAULT_NONE;
   assign load_data_o  = ((r_state == S_RESP) && r_is_load && (r_fault == FAULT_NONE))
                         ? w_load_aligned : 32'd0;

endmodule
`default_nettype wire
